// File: rtl/cache_l1_param.sv
// Direct-mapped write-through L1 cache, registered memory strobes, flush sequencer.
// Optional hit/miss counters when CACHE_L1_STATS_EN is defined.
module cache_l1_param #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              readEnable,
    input  logic              writeEnable,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              flush,
    output logic [DATA_W-1:0] dataOut,
    output logic              cacheReady,
    input  logic [DATA_W-1:0] memoryDataIn,
    output logic [DATA_W-1:0] memoryDataOut,
    output logic [ADDR_W-1:0] memoryAddress,
    output logic              memoryReadEnable,
    output logic              memoryWriteEnable,
    input  logic              memoryReady
`ifdef CACHE_L1_STATS_EN
    ,
    output logic [31:0]       hitCount,
    output logic [31:0]       missCount
`endif
);

    localparam int LINES = 1 << INDEX_BITS;

    if (INDEX_BITS + TAG_BITS + 2 > ADDR_W - 1) begin : g_geom_err
        $error("cache_l1_param: index+tag+2 must not exceed ADDR_W-1");
    end

    typedef enum logic [2:0] {
        IDLE,
        READ_MISS,
        WRITE_THRU,
        RESPOND,
        FLUSH
    } state_t;

    state_t state, state_nx;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [DATA_W-1:0]     data [LINES];
    logic [DATA_W-1:0]     resp;
    logic [INDEX_BITS-1:0] flush_cnt;

    logic [INDEX_BITS-1:0] idx, mem_idx;
    logic [TAG_BITS-1:0]   tg, mem_tg;
    logic                  hit, mem_hit, mem_cached;
    logic                  ready, go_rd, go_wr, rd_done, wr_done, rd_hit;
    logic                  unused_bits;

    assign idx        = address[INDEX_BITS+1:2];
    assign tg         = address[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign mem_idx    = memoryAddress[INDEX_BITS+1:2];
    assign mem_tg     = memoryAddress[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign mem_cached = ~memoryAddress[ADDR_W-1];
    assign hit        = valid[idx] & (tags[idx] == tg) & ~address[ADDR_W-1];
    assign mem_hit    = valid[mem_idx] & (tags[mem_idx] == mem_tg) & mem_cached;
    assign unused_bits = ^{address, memoryAddress};

    assign cacheReady = ready;
    assign dataOut    = (state == RESPOND) ? resp : data[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        go_rd    = 1'b0;
        go_wr    = 1'b0;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        rd_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                // With flush pending a request is held off, but a bare idle stays ready
                ready = ~(readEnable | writeEnable)
                      | (readEnable & hit & ~flush);
                if (flush) begin
                    state_nx = FLUSH;
                end else if (readEnable) begin
                    rd_hit = hit;
                    go_rd  = ~hit;
                    if (!hit) state_nx = READ_MISS;
                end else if (writeEnable) begin
                    go_wr    = 1'b1;
                    state_nx = WRITE_THRU;
                end
            end
            READ_MISS: begin
                rd_done = memoryReady;
                if (memoryReady) state_nx = RESPOND;
            end
            WRITE_THRU: begin
                wr_done = memoryReady;
                if (memoryReady) state_nx = RESPOND;
            end
            RESPOND: begin
                ready    = 1'b1;
                state_nx = IDLE;
            end
            FLUSH: begin
                if (&flush_cnt) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid             <= '0;
            resp              <= '0;
            flush_cnt         <= '0;
            memoryAddress     <= '0;
            memoryDataOut     <= '0;
            memoryReadEnable  <= 1'b0;
            memoryWriteEnable <= 1'b0;
        end else begin
            if (go_rd) begin
                memoryAddress    <= address;
                memoryReadEnable <= 1'b1;
            end
            if (go_wr) begin
                memoryAddress     <= address;
                memoryDataOut     <= dataIn;
                memoryWriteEnable <= 1'b1;
            end
            if (rd_done) begin
                resp             <= memoryDataIn;
                memoryReadEnable <= 1'b0;
                if (mem_cached) valid[mem_idx] <= 1'b1;
            end
            if (wr_done) memoryWriteEnable <= 1'b0;
            if (state == FLUSH) begin
                valid[flush_cnt] <= 1'b0;
                flush_cnt        <= flush_cnt + 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (rd_done && mem_cached) begin
            data[mem_idx] <= memoryDataIn;
            tags[mem_idx] <= mem_tg;
        end else if (wr_done && mem_hit) begin
            data[mem_idx] <= memoryDataOut;
        end
    end

`ifdef CACHE_L1_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (rd_hit && !flush && hitCount != '1)
                hitCount <= hitCount + 1'b1;
            if (go_rd && !address[ADDR_W-1] && missCount != '1)
                missCount <= missCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_l1_param.sv
// Randomized bench for cache_l1_param against an array/queue-level cache model.
// Directed test-plan sequence first, then random reads, writes and flushes.
module tb_cache_l1_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        readEnable, writeEnable, flush;
    logic [31:0] dataIn, dataOut;
    logic        cacheReady;
    logic [31:0] memoryDataIn, memoryDataOut, memoryAddress;
    logic        memoryReadEnable, memoryWriteEnable, memoryReady;
`ifdef CACHE_L1_STATS_EN
    logic [31:0] hitCount, missCount;
`endif

    always #5 clk = ~clk;

    cache_l1_param dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .readEnable(readEnable),
        .writeEnable(writeEnable),
        .dataIn(dataIn),
        .flush(flush),
        .dataOut(dataOut),
        .cacheReady(cacheReady),
        .memoryDataIn(memoryDataIn),
        .memoryDataOut(memoryDataOut),
        .memoryAddress(memoryAddress),
        .memoryReadEnable(memoryReadEnable),
        .memoryWriteEnable(memoryWriteEnable),
        .memoryReady(memoryReady)
`ifdef CACHE_L1_STATS_EN
        ,
        .hitCount(hitCount),
        .missCount(missCount)
`endif
    );

    int total = 0;
    int bad   = 0;

    // cache model: 32 lines, index a[6:2], tag a[10:7]
    bit          vm [32];
    logic [3:0]  tm [32];
    logic [31:0] dm [32];
    logic [31:0] mem [logic [31:0]];
    int          mreads = 0, mwrites = 0;
    int          hits_m = 0, miss_m = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    int          lat_min = 1, lat_max = 4;
    bit          stray_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // memory: random latency, checks the registered address/data it sees
    initial begin
        int ctr, lat;
        ctr = 0;
        lat = 1;
        memoryReady  = 1'b0;
        memoryDataIn = '0;
        forever begin
            @(posedge clk);
            #2;
            memoryReady = 1'b0;
            if (memoryReadEnable || memoryWriteEnable) begin
                if (ctr == 0) lat = $urandom_range(lat_min, lat_max);
                ctr++;
                if (ctr >= lat) begin
                    ctr = 0;
                    memoryReady = 1'b1;
                    chk("mem_addr", memoryAddress, exp_addr);
                    if (memoryReadEnable) begin
                        mreads++;
                        memoryDataIn = mem.exists(memoryAddress) ?
                                       mem[memoryAddress] : 32'hbad0bad0;
                    end else begin
                        mwrites++;
                        chk("mem_wdata", memoryDataOut, exp_wdata);
                        mem[memoryAddress] = memoryDataOut;
                    end
                end
            end else begin
                ctr = 0;
                if (stray_en && $urandom_range(0, 7) == 0) begin
                    memoryReady  = 1'b1;
                    memoryDataIn = $urandom;
                end
            end
        end
    end

    function automatic bit model_hit(input logic [31:0] a);
        return !a[31] && vm[a[6:2]] && tm[a[6:2]] == a[10:7];
    endfunction

    task automatic cpu_read(input logic [31:0] a);
        logic [4:0]  i;
        logic [31:0] e;
        bit          h;
        int          r0, n;
        i = a[6:2];
        h = model_hit(a);
        if (!mem.exists(a)) mem[a] = $urandom;
        e = h ? dm[i] : mem[a];
        r0 = mreads;
        exp_addr = a;
        address = a;
        readEnable = 1'b1;
        #1;
        if (h) begin
            chk("rd_hit_ready", cacheReady, 1);
        end else begin
            chk("rd_miss_busy", cacheReady, 0);
            @(posedge clk);
            #1;
            chk("rd_strobe", memoryReadEnable, 1);
            n = 0;
            while (!cacheReady && n < 60) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("rd_timeout", n < 60, 1);
        end
        chk("rd_data", dataOut, e);
        @(posedge clk);
        #1;
        readEnable = 1'b0;
        chk("rd_memreads", mreads - r0, h ? 0 : 1);
        if (h) hits_m++;
        if (!h && !a[31]) begin
            vm[i] = 1'b1;
            tm[i] = a[10:7];
            dm[i] = e;
            miss_m++;
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        bit h;
        int w0, n;
        h = model_hit(a);
        w0 = mwrites;
        exp_addr = a;
        exp_wdata = d;
        address = a;
        dataIn = d;
        writeEnable = 1'b1;
        #1;
        chk("wr_busy", cacheReady, 0);
        @(posedge clk);
        #1;
        chk("wr_strobe", memoryWriteEnable, 1);
        chk("wr_mdata", memoryDataOut, d);
        n = 0;
        while (!cacheReady && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wr_timeout", n < 60, 1);
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        dataIn = $urandom;
        chk("wr_memwrites", mwrites - w0, 1);
        if (h) dm[a[6:2]] = d;
    endtask

    task automatic do_flush();
        int n;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        while (!cacheReady && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("flush_cycles", n, 32);
        foreach (vm[k]) vm[k] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1;
        address = '0;
        readEnable = 1'b0;
        writeEnable = 1'b0;
        flush = 1'b0;
        dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_ready", cacheReady, 1);
        chk("rst_mre", memoryReadEnable, 0);
        chk("rst_mwe", memoryWriteEnable, 0);
        chk("rst_maddr", memoryAddress, 0);
        chk("rst_mdout", memoryDataOut, 0);
        @(posedge clk);
        #1;

        mem[32'h40] = 32'hDEADBEEF;
        cpu_read(32'h40);
        cpu_read(32'h40);
        cpu_write(32'h40, 32'h12345678);
        cpu_read(32'h40);
        cpu_write(32'hC0, 32'hAAAAAAAA);
        cpu_read(32'h40);
        cpu_read(32'h80000040);
        cpu_read(32'h40);
        do_flush();
        cpu_read(32'h40);
        do_flush();

        // reset two cycles into a read miss
        lat_min = 10;
        lat_max = 10;
        exp_addr = 32'h40;
        address = 32'h40;
        readEnable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_pre", memoryReadEnable, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mre", memoryReadEnable, 0);
        readEnable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", cacheReady, 1);
        foreach (vm[k]) vm[k] = 1'b0;
        hits_m = 0;
        miss_m = 0;
        lat_min = 1;
        lat_max = 4;
        @(posedge clk);
        #1;
        cpu_read(32'h40);
`ifdef CACHE_L1_STATS_EN
        chk("rst_hitcnt", hitCount, hits_m);
        chk("rst_misscnt", missCount, miss_m);
`endif

        for (int k = 0; k < 400; k++) begin
            a = {($urandom_range(0, 9) == 0), 20'd0,
                 4'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 2'b00};
            r = $urandom_range(0, 99);
            if (r < 3)       do_flush();
            else if (r < 45) cpu_write(a, $urandom);
            else             cpu_read(a);
        end
`ifdef CACHE_L1_STATS_EN
        chk("hitcnt", hitCount, hits_m);
        chk("misscnt", missCount, miss_m);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
